// File: rtl/switch_debounce_pkg.sv
// Shared types and default constants for the switch synchronizer/debouncer.
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    CHECK1  = 2'd1,
    STABLE1 = 2'd2,
    CHECK0  = 2'd3
  } debounce_state_t;

  localparam int SW_SYNC_STAGES_DEF     = 2;
  localparam int SW_DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchronizer chain, debounce FSM and counter.
// Optional RISE/FALL pulse flops are built when SWITCH_DEBOUNCE_EDGE_EN is defined.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SW_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  debounce_state_t        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE0;
      cnt_q   <= '0;
      level   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    case (state_q)
      STABLE0: if (s) begin
        state_d = CHECK1;
        cnt_d   = CNT_ONE;
      end
      CHECK1: begin
        if (!s) begin
          state_d = STABLE0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE1: if (!s) begin
        state_d = CHECK0;
        cnt_d   = CNT_ONE;
      end
      CHECK0: begin
        if (s) begin
          state_d = STABLE1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE0;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE0;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  // Pulses are registered on the same edge that updates level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= level_d & ~level;
      fall <= ~level_d & level;
    end
  end
`endif

endmodule

// File: rtl/switch_debounce.sv
// WIDTH independent switch debouncers. Define SWITCH_DEBOUNCE_EDGE_EN to add
// registered one-cycle RISE/FALL pulse outputs.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = SW_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`endif
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (CLK),
      .rst_n(RESETN),
      .raw  (I[b]),
      .level(O[b]),
      .rise (RISE[b]),
      .fall (FALL[b])
    );
`else
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (CLK),
      .rst_n(RESETN),
      .raw  (I[b]),
      .level(O[b])
    );
`endif
  end

endmodule
